// File: rtl/spi_sram_frame_ctrl.sv
// SPI-slave frame controller: decodes opcode/address/data bursts from sdi and
// drives single-cycle SRAM strobes, serialising read data back on sdo.
module spi_sram_frame_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [7:0] OP_WRITE = 8'h02,
  parameter logic [7:0] OP_READ  = 8'h03
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              bad_op
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                           : ((DATA_W > 8) ? DATA_W : 8);
  localparam int CNT_W = $clog2(MAX_W);

  typedef enum logic [2:0] {CMD, ADDR, WRITE, READ, HOLD} state_t;

  state_t            state;
  logic              mode_rd;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        op_sr;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] wsr;
  logic [DATA_W-1:0] rd_sr;
  logic [7:0]        op_word;

  // Opcode is complete on the edge that samples its last bit.
  assign op_word = {op_sr[6:0], sdi};

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state      <= CMD;
      mode_rd    <= 1'b0;
      bit_cnt    <= '0;
      op_sr      <= '0;
      addr_sr    <= '0;
      wsr        <= '0;
      rd_sr      <= '0;
      sdo        <= 1'b0;
      sdo_oe     <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      bad_op     <= 1'b0;
    end else if (cs_n) begin
      state   <= CMD;
      bit_cnt <= '0;
      sram_we <= 1'b0;
      sram_re <= 1'b0;
      sdo_oe  <= 1'b0;
      sdo     <= 1'b0;
      bad_op  <= 1'b0;
    end else begin
      sram_we <= 1'b0;
      sram_re <= 1'b0;
      bad_op  <= 1'b0;
      case (state)
        CMD: begin
          op_sr <= op_word;
          if (bit_cnt == CNT_W'(7)) begin
            bit_cnt <= '0;
            if (op_word == OP_WRITE) begin
              state   <= ADDR;
              mode_rd <= 1'b0;
            end else if (op_word == OP_READ) begin
              state   <= ADDR;
              mode_rd <= 1'b1;
            end else begin
              state  <= HOLD;
              bad_op <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ADDR: begin
          addr_sr <= {addr_sr[ADDR_W-2:0], sdi};
          if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
            bit_cnt   <= '0;
            sram_addr <= {addr_sr[ADDR_W-2:0], sdi};
            if (mode_rd) begin
              state   <= READ;
              sram_re <= 1'b1;
              sdo_oe  <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WRITE: begin
          wsr <= {wsr[DATA_W-2:0], sdi};
          // Advance only after the strobe has been seen at the old address.
          if (sram_we) sram_addr <= sram_addr + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            bit_cnt    <= '0;
            sram_wdata <= {wsr[DATA_W-2:0], sdi};
            sram_we    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        READ: begin
          if (bit_cnt == '0) begin
            rd_sr <= sram_rdata;
            sdo   <= sram_rdata[DATA_W-1];
          end else begin
            rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
            sdo   <= rd_sr[DATA_W-2];
          end
          // Prefetch the next word so it is ready at the following word edge 0.
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            bit_cnt   <= '0;
            sram_addr <= sram_addr + 1'b1;
            sram_re   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_frame_ctrl.sv
// Bench for spi_sram_frame_ctrl: frame-position model checked every cycle,
// plus literal per-scenario expectations on logged strobes and read bytes.
module tb_spi_sram_frame_ctrl;

  logic       sck = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo, sdo_oe, sram_we, sram_re, bad_op;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;
  logic [7:0] mem [256];

  spi_sram_frame_ctrl dut (
    .sck(sck), .rst(rst), .cs_n(cs_n), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_re(sram_re), .sram_rdata(sram_rdata), .bad_op(bad_op)
  );

  always #5 sck = ~sck;
  assign sram_rdata = mem[sram_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: outputs follow from the bit position n within the current frame.
  int         n;
  logic [7:0] op, a, last8, m_addr, m_wdata;
  logic       m_we, m_re, m_oe, m_sdo, m_bad;

  always @(posedge sck or posedge rst) begin
    if (rst) begin
      n = 0; op = 0; a = 0; last8 = 0; m_addr = 0; m_wdata = 0;
      {m_we, m_re, m_oe, m_sdo, m_bad} = 5'b0;
    end else if (cs_n) begin
      n = 0;
      {m_we, m_re, m_oe, m_sdo, m_bad} = 5'b0;
    end else begin
      n++;
      last8 = {last8[6:0], sdi};
      {m_we, m_re, m_oe, m_sdo, m_bad} = 5'b0;
      if (n == 8) begin
        op = last8;
        m_bad = (op != 8'h02) && (op != 8'h03);
      end
      if (n == 16) a = last8;
      if (n >= 16 && op == 8'h02) begin
        if (n > 16 && (n - 16) % 8 == 0) begin
          m_we = 1'b1;
          m_wdata = last8;
        end
        m_addr = (n <= 16) ? a : 8'(a + (n - 17) / 8);
      end
      if (n >= 16 && op == 8'h03) begin
        m_oe = 1'b1;
        m_re = ((n - 16) % 8 == 0);
        m_addr = 8'(a + (n - 16) / 8);
        if (n >= 17) m_sdo = mem[8'(a + (n - 17) / 8)][7 - ((n - 17) % 8)];
      end
    end
  end

  logic [7:0] wr_a[$], wr_d[$], re_a[$], rd_q[$];
  logic [7:0] rd_acc;
  int         bad_cnt;
  logic       oe_seen;

  always @(posedge sck) begin
    #1;
    chk("we", {7'b0, sram_we}, {7'b0, m_we});
    chk("re", {7'b0, sram_re}, {7'b0, m_re});
    chk("sdo_oe", {7'b0, sdo_oe}, {7'b0, m_oe});
    chk("sdo", {7'b0, sdo}, {7'b0, m_sdo});
    chk("bad_op", {7'b0, bad_op}, {7'b0, m_bad});
    chk("addr", sram_addr, m_addr);
    chk("wdata", sram_wdata, m_wdata);
    if (sram_we) begin wr_a.push_back(sram_addr); wr_d.push_back(sram_wdata); end
    if (sram_re) re_a.push_back(sram_addr);
    if (bad_op) bad_cnt++;
    if (sdo_oe) oe_seen = 1'b1;
    if (m_oe && n >= 17) begin
      rd_acc = {rd_acc[6:0], sdo};
      if ((n - 17) % 8 == 7) rd_q.push_back(rd_acc);
    end
  end

  task automatic send(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      @(negedge sck);
      cs_n = 1'b0;
      sdi = v[i];
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge sck);
      cs_n = 1'b1;
      sdi = 1'b0;
    end
  endtask

  task automatic clr();
    wr_a.delete(); wr_d.delete(); re_a.delete(); rd_q.delete();
    bad_cnt = 0;
    oe_seen = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    clr();
    repeat (3) @(negedge sck);
    rst = 1'b0;
    idle(2);

    // 1: reset pulse mid-address, then a clean write frame
    clr();
    send(32'h02A, 12);
    @(negedge sck); rst = 1'b1;
    @(negedge sck); rst = 1'b0;
    idle(2);
    send(32'h0210A5, 24);
    idle(3);
    chk("t1_we_count", 8'(wr_a.size()), 8'd1);
    chk("t1_addr", wr_a.size() > 0 ? wr_a[0] : 8'hxx, 8'h10);
    chk("t1_wdata", wr_d.size() > 0 ? wr_d[0] : 8'hxx, 8'hA5);
    $display("t1 write frame: writes=%0d", wr_a.size());

    // 2: burst write wrapping from 0xFF to 0x00
    clr();
    send(32'h02FF1122, 32);
    idle(3);
    chk("t2_we_count", 8'(wr_a.size()), 8'd2);
    chk("t2_addr0", wr_a.size() > 0 ? wr_a[0] : 8'hxx, 8'hFF);
    chk("t2_wdata0", wr_d.size() > 0 ? wr_d[0] : 8'hxx, 8'h11);
    chk("t2_addr1", wr_a.size() > 1 ? wr_a[1] : 8'hxx, 8'h00);
    chk("t2_wdata1", wr_d.size() > 1 ? wr_d[1] : 8'hxx, 8'h22);
    $display("t2 burst write: writes=%0d", wr_a.size());

    // 3: burst read of two words from 0x20
    clr();
    send(32'h0320, 16);
    send(32'h0, 16);
    idle(2);
    chk("t3_re_addr0", re_a.size() > 0 ? re_a[0] : 8'hxx, 8'h20);
    chk("t3_re_addr1", re_a.size() > 1 ? re_a[1] : 8'hxx, 8'h21);
    chk("t3_byte0", rd_q.size() > 0 ? rd_q[0] : 8'hxx, 8'h5A);
    chk("t3_byte1", rd_q.size() > 1 ? rd_q[1] : 8'hxx, 8'hC3);
    $display("t3 burst read: reads=%0d bytes=%0d", re_a.size(), rd_q.size());

    // 4: unknown opcode
    clr();
    send(32'h9C, 8);
    send(32'h3FF, 10);
    idle(2);
    chk("t4_bad_count", 8'(bad_cnt), 8'd1);
    chk("t4_we_count", 8'(wr_a.size()), 8'd0);
    chk("t4_re_count", 8'(re_a.size()), 8'd0);
    chk("t4_oe_seen", {7'b0, oe_seen}, 8'd0);
    $display("t4 bad opcode: pulses=%0d", bad_cnt);

    // 5: truncated write, then a complete one
    clr();
    send(32'h0240, 16);
    send(32'b10110, 5);
    idle(2);
    send(32'h02413C, 24);
    idle(3);
    chk("t5_we_count", 8'(wr_a.size()), 8'd1);
    chk("t5_addr", wr_a.size() > 0 ? wr_a[0] : 8'hxx, 8'h41);
    chk("t5_wdata", wr_d.size() > 0 ? wr_d[0] : 8'hxx, 8'h3C);
    $display("t5 truncated write: writes=%0d", wr_a.size());

    // 6: read wrapping from 0xFF to 0x00
    clr();
    send(32'h03FF, 16);
    send(32'h0, 8);
    idle(2);
    chk("t6_re_count", 8'(re_a.size()), 8'd2);
    chk("t6_re_addr0", re_a.size() > 0 ? re_a[0] : 8'hxx, 8'hFF);
    chk("t6_re_addr1", re_a.size() > 1 ? re_a[1] : 8'hxx, 8'h00);
    $display("t6 wrap read: reads=%0d", re_a.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
